// File: rtl/mac_column_engine.sv
// Column multiply-accumulate engine: four row accumulators fed from the X operand buffer,
// one coefficient per cycle, eight products per column, results handed off by valid/ready.
//
// state     | meaning
// S_IDLE    | waiting for start; outputs quiet
// S_COMPUTE | accepting coefficients, rotating the X buffer, accumulating 8 products
// S_OUT     | column results presented until the consumer accepts them
module mac_column_engine #(
    parameter int N_COLS = 4,
    parameter int K_LEN  = 8,
    parameter int ACC_W  = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       x_in1,
    input  logic [7:0]       x_in2,
    input  logic [7:0]       x_in3,
    input  logic [7:0]       x_in4,
    input  logic [7:0]       coef,
    input  logic             coef_valid,
    output logic             coef_ready,
    output logic             x_shift,
    output logic [ACC_W-1:0] result1,
    output logic [ACC_W-1:0] result2,
    output logic [ACC_W-1:0] result3,
    output logic [ACC_W-1:0] result4,
    output logic [3:0]       result_col,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_OUT} state_t;

    localparam logic [3:0] LAST_COL = 4'(N_COLS - 1);
    localparam logic [2:0] LAST_K   = 3'(K_LEN - 1);

    state_t           state, state_nx;
    logic [3:0]       col;
    logic [2:0]       k;
    logic [ACC_W-1:0] acc   [4];
    logic [7:0]       x_row [4];
    logic [15:0]      prod  [4];
    logic             hs;
    logic             out_hs;
    logic             done_r;

    assign x_row[0] = x_in1;
    assign x_row[1] = x_in2;
    assign x_row[2] = x_in3;
    assign x_row[3] = x_in4;

    for (genvar r = 0; r < 4; r++) begin : g_prod
        assign prod[r] = {8'd0, x_row[r]} * {8'd0, coef};
    end

    assign hs      = coef_valid & coef_ready;
    assign out_hs  = result_valid & result_ready;
    assign x_shift = hs;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_COMPUTE;
            S_COMPUTE: if (hs && k == LAST_K) state_nx = S_OUT;
            S_OUT:     if (out_hs) state_nx = (col == LAST_COL) ? S_IDLE : S_COMPUTE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        coef_ready   = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_COMPUTE: coef_ready   = 1'b1;
            S_OUT:     result_valid = 1'b1;
            default:   ;
        endcase
    end

    // k==0 overwrites rather than adds, which is what clears the previous column.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col    <= '0;
            k      <= '0;
            done_r <= 1'b0;
            for (int r = 0; r < 4; r++) acc[r] <= '0;
        end else begin
            done_r <= out_hs && (col == LAST_COL);
            if (state == S_IDLE && start) begin
                col <= '0;
                k   <= '0;
            end
            if (hs) begin
                k <= (k == LAST_K) ? 3'd0 : k + 3'd1;
                for (int r = 0; r < 4; r++)
                    acc[r] <= ((k == 3'd0) ? '0 : acc[r]) + {3'd0, prod[r]};
            end
            if (out_hs)
                col <= (col == LAST_COL) ? 4'd0 : col + 4'd1;
        end
    end

    assign result1    = acc[0];
    assign result2    = acc[1];
    assign result3    = acc[2];
    assign result4    = acc[3];
    assign result_col = col;
    assign done       = done_r;

endmodule
